// File: rtl/sump_cmd_deframer_pkg.sv
// ============================================================================
// sump_cmd_deframer_pkg - shared opcode type and deframer state.  Rev 1.0
// ============================================================================
`default_nettype none

package sump_cmd_deframer_pkg;

  typedef logic [7:0] opcode_t;

  localparam opcode_t SOFT_RST_OPC = 8'h00;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } dfr_state_e;

  function automatic logic is_long(input opcode_t opc);
    return opc[7];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sump_timeout_cnt.sv
// ============================================================================
// sump_timeout_cnt - loadable saturating up/down counter with expire pulse.  Rev 1.0
// ============================================================================
`default_nettype none

module sump_timeout_cnt #(
  parameter  int unsigned LIMIT = 16,
  localparam int unsigned W     = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         up_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         expire_o
);

  localparam logic [W-1:0] C_MAX = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;
  logic         step;

  assign step  = en_i && !clr_i && !load_i;
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      if (up_i && (cnt_q != C_MAX)) begin
        cnt_d = cnt_q + W'(1);
      end else if (!up_i && (cnt_q != '0)) begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expire fires in the cycle whose step lands on the limit (or on zero counting down).
  generate
    if (LIMIT > 0) begin : g_limit
      assign expire_o = step && (up_i ? (cnt_q == C_MAX - W'(1)) : (cnt_q == W'(1)));
    end else begin : g_nolimit
      assign expire_o = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/sump_cmd_deframer.sv
// ============================================================================
// sump_cmd_deframer - SUMP/OLS byte stream to command deframer.  Rev 1.0
// ============================================================================
`default_nettype none

module sump_cmd_deframer
  import sump_cmd_deframer_pkg::*;
#(
  parameter int unsigned CMD_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned RST_REPEAT  = 5
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_stb_i,
  output opcode_t          opcode_o,
  output logic [CMD_W-1:0] payload_o,
  output logic             long_o,
  output logic             cmd_stb_o,
  output logic             soft_rst_o,
  output logic             timeout_o,
  output logic             busy_o
);

  localparam int unsigned NB  = CMD_W / 8;
  localparam int unsigned BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned RCW = $clog2(RST_REPEAT + 1);
  localparam int unsigned TCW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [BCW-1:0] C_LAST_BYTE  = BCW'(NB - 1);
  localparam logic [RCW-1:0] C_REP_LAST   = RCW'(RST_REPEAT - 1);

  dfr_state_e       state_q,    state_d;
  opcode_t          opc_q,      opc_d;
  logic [CMD_W-1:0] shreg_q,    shreg_d;
  logic [BCW-1:0]   bcnt_q,     bcnt_d;
  logic [RCW-1:0]   rep_q,      rep_d;
  opcode_t          opcode_q,   opcode_d;
  logic [CMD_W-1:0] payload_q,  payload_d;
  logic             long_q,     long_d;
  logic             cmd_stb_q,  cmd_stb_d;
  logic             soft_rst_q, soft_rst_d;
  logic             timeout_q,  timeout_d;

  logic             tmo_expire;
  logic [TCW-1:0]   tmo_cnt_unused;

  sump_timeout_cnt #(
    .LIMIT      (TIMEOUT_CYC)
  ) u_tmo (
    .clk_i      (clk_i),
    .rst_ni     (rst_in),
    .clr_i      ((state_q != PAYLOAD) || rx_stb_i),
    .load_i     (1'b0),
    .load_val_i ('0),
    .up_i       (1'b1),
    .en_i       ((state_q == PAYLOAD) && !rx_stb_i),
    .cnt_o      (tmo_cnt_unused),
    .expire_o   (tmo_expire)
  );

  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    shreg_d    = shreg_q;
    bcnt_d     = bcnt_q;
    rep_d      = rep_q;
    opcode_d   = opcode_q;
    payload_d  = payload_q;
    long_d     = long_q;
    cmd_stb_d  = 1'b0;
    soft_rst_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_stb_i) begin
          if (is_long(rx_data_i)) begin
            state_d = PAYLOAD;
            opc_d   = rx_data_i;
            shreg_d = '0;
            bcnt_d  = '0;
            rep_d   = '0;
          end else begin
            opcode_d  = rx_data_i;
            payload_d = '0;
            long_d    = 1'b0;
            cmd_stb_d = 1'b1;
            if (rx_data_i == SOFT_RST_OPC) begin
              if (rep_q == C_REP_LAST) begin
                rep_d      = '0;
                soft_rst_d = 1'b1;
              end else begin
                rep_d = rep_q + RCW'(1);
              end
            end else begin
              rep_d = '0;
            end
          end
        end
      end
      PAYLOAD: begin
        // A byte arriving in the expiry cycle takes priority over the timeout.
        if (rx_stb_i) begin
          shreg_d[8*bcnt_q +: 8] = rx_data_i;
          bcnt_d                 = bcnt_q + BCW'(1);
          if (bcnt_q == C_LAST_BYTE) begin
            state_d   = IDLE;
            opcode_d  = opc_q;
            payload_d = shreg_d;
            long_d    = 1'b1;
            cmd_stb_d = 1'b1;
          end
        end else if (tmo_expire) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      opc_q      <= '0;
      shreg_q    <= '0;
      bcnt_q     <= '0;
      rep_q      <= '0;
      opcode_q   <= '0;
      payload_q  <= '0;
      long_q     <= 1'b0;
      cmd_stb_q  <= 1'b0;
      soft_rst_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      opc_q      <= opc_d;
      shreg_q    <= shreg_d;
      bcnt_q     <= bcnt_d;
      rep_q      <= rep_d;
      opcode_q   <= opcode_d;
      payload_q  <= payload_d;
      long_q     <= long_d;
      cmd_stb_q  <= cmd_stb_d;
      soft_rst_q <= soft_rst_d;
      timeout_q  <= timeout_d;
    end
  end

  assign opcode_o   = opcode_q;
  assign payload_o  = payload_q;
  assign long_o     = long_q;
  assign cmd_stb_o  = cmd_stb_q;
  assign soft_rst_o = soft_rst_q;
  assign timeout_o  = timeout_q;
  assign busy_o     = (state_q == PAYLOAD);

endmodule

`default_nettype wire
